// File: rtl/ysyx_25060170_isram.sv
// rtl/ysyx_25060170_isram.sv - fixed-latency instruction memory responder for IFU fetch
module ysyx_25060170_isram #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [31:0]           req_addr,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [31:0]           resp_data,
  output logic                  resp_err,
  input  logic                  resp_ready,
  input  logic                  flush,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data
);
  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state;
  state_t                state_next;
  logic [3:0]            cnt;
  logic [31:0]           addr_q;
  logic [31:0]           off;
  logic                  fault;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  accept;
  logic                  done;
  logic [31:0]           mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid && req_ready) state_next = BUSY;
      BUSY:    if (flush) state_next = IDLE;
               else if (cnt == 4'd0) state_next = RESP;
      RESP:    if (flush || resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE) && !flush;
    resp_valid = (state == RESP);
  end

  assign accept = (state == IDLE) && req_valid && !flush;
  assign done   = (state == BUSY) && !flush && (cnt == 4'd0);

  // Addresses below BASE wrap to a huge offset and fall out of range.
  assign off   = addr_q - BASE;
  assign fault = (addr_q[1:0] != 2'b00) || ({1'b0, off} >= SPAN);
  assign idx   = off[DEPTH_LOG2+1:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 4'd0;
      addr_q    <= 32'd0;
      resp_data <= 32'd0;
      resp_err  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= req_addr;
        cnt    <= CNT_INIT;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Read samples the array before a same-edge load lands.
      if (done) begin
        resp_err  <= fault;
        resp_data <= fault ? 32'd0 : mem[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end
endmodule

// File: tb/tb_ysyx_25060170_isram.sv
// tb/tb_ysyx_25060170_isram.sv - directed bench for the instruction memory responder
module tb_ysyx_25060170_isram;
  logic        clk = 0, rst = 0, req_valid = 0, resp_ready = 0, flush = 0, ld_en = 0;
  logic [31:0] req_addr = 0, ld_data = 0;
  logic [9:0]  ld_addr = 0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_data;
  logic        rr1, rv1, re1, rr15, rv15, re15;
  logic [31:0] rd1, rd15;
  int          tests = 0, fails = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  ysyx_25060170_isram #(.DEPTH_LOG2(10), .BASE(32'h8000_0000), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err), .resp_ready(resp_ready),
    .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  ysyx_25060170_isram #(.DEPTH_LOG2(10), .BASE(32'h8000_0000), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(rr1),
    .resp_valid(rv1), .resp_data(rd1), .resp_err(re1), .resp_ready(resp_ready),
    .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  ysyx_25060170_isram #(.DEPTH_LOG2(10), .BASE(32'h8000_0000), .LATENCY(15)) dut15 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(rr15),
    .resp_valid(rv15), .resp_data(rd15), .resp_err(re15), .resp_ready(resp_ready),
    .flush(flush), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    ld_en = 1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 0;
  endtask

  // Called at a negedge with the DUT idle; lat counts edges from accept to resp_valid.
  task automatic fetch(input logic [31:0] a, output logic [31:0] d, output logic e, output int lat);
    req_valid = 1; req_addr = a; resp_ready = 1;
    @(negedge clk);
    req_valid = 0; lat = 0;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    d = resp_data; e = resp_err;
    @(negedge clk);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        e;
    logic        seen;
    int          lat, l1, l2, l15;
    logic [31:0] d15;

    vecs[0] = '{32'h8000_0000, 32'h0000_0413, 1'b0};
    vecs[1] = '{32'h8000_0004, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{32'h8000_0002, 32'h0000_0000, 1'b1};
    vecs[3] = '{32'h8000_1000, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h7FFF_FFFC, 32'h0000_0000, 1'b1};
    vecs[5] = '{32'h8000_0FFC, 32'hCAFE_F00D, 1'b0};
    vecs[6] = '{32'h8000_0008, 32'h1234_5678, 1'b0};
    vecs[7] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1};

    // Reset state with a request held; preload runs while reset is low.
    req_valid = 1; req_addr = 32'h8000_0000; resp_ready = 1;
    @(negedge clk);
    chkb("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 32'h0);
    chkb("rst_resp_err", resp_err, 1'b0);
    chkb("rst_req_ready", req_ready, 1'b1);
    load(10'd0, 32'h0000_0413);
    load(10'd1, 32'hDEAD_BEEF);
    load(10'd2, 32'h1234_5678);
    load(10'd3, 32'h2222_2222);
    load(10'd1023, 32'hCAFE_F00D);
    chkb("rst_no_accept", resp_valid, 1'b0);

    // Test 1: accept on first edge after reset release.
    rst = 1;
    #1 chkb("t1_req_ready", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 0;
    chkb("t1_busy_ready", req_ready, 1'b0);
    @(negedge clk);
    chkb("t1_e1_valid", resp_valid, 1'b0);
    @(negedge clk);
    chkb("t1_e2_valid", resp_valid, 1'b1);
    chk("t1_data", resp_data, 32'h0000_0413);
    chkb("t1_err", resp_err, 1'b0);
    @(negedge clk);
    chkb("t1_done_valid", resp_valid, 1'b0);
    chkb("t1_done_ready", req_ready, 1'b1);

    for (int i = 0; i < 8; i++) begin
      fetch(vecs[i].addr, d, e, lat);
      chk($sformatf("vec%0d_data", i), d, vecs[i].data);
      chkb($sformatf("vec%0d_err", i), e, vecs[i].err);
      chk($sformatf("vec%0d_lat", i), lat, 2);
    end

    // Back-pressure, with a load to the same word while the response is held.
    resp_ready = 0; req_valid = 1; req_addr = 32'h8000_0004;
    @(negedge clk);
    req_valid = 0;
    wait_valid(lat);
    chk("bp_lat", lat, 2);
    ld_en = 1; ld_addr = 10'd1; ld_data = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ld_en = 0;
      chkb($sformatf("bp%0d_valid", i), resp_valid, 1'b1);
      chk($sformatf("bp%0d_data", i), resp_data, 32'hDEAD_BEEF);
      chkb($sformatf("bp%0d_req_ready", i), req_ready, 1'b0);
    end
    resp_ready = 1;
    @(negedge clk);
    chkb("bp_done_valid", resp_valid, 1'b0);
    chkb("bp_done_ready", req_ready, 1'b1);

    // Flush in BUSY.
    req_valid = 1; req_addr = 32'h8000_0000;
    @(negedge clk);
    req_valid = 0; flush = 1;
    #1 chkb("fb_req_ready_flush", req_ready, 1'b0);
    @(negedge clk);
    flush = 0;
    #1 chkb("fb_req_ready", req_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen = seen | resp_valid;
    end
    chkb("fb_no_resp", seen, 1'b0);
    fetch(32'h8000_0008, d, e, lat);
    chk("fb_next_data", d, 32'h1234_5678);
    chk("fb_next_lat", lat, 2);

    // Flush together with resp_ready in RESP.
    resp_ready = 0; req_valid = 1; req_addr = 32'h8000_0000;
    @(negedge clk);
    req_valid = 0;
    wait_valid(lat);
    chkb("fr_valid", resp_valid, 1'b1);
    flush = 1; resp_ready = 1;
    @(negedge clk);
    flush = 0;
    #1 chkb("fr_valid_drop", resp_valid, 1'b0);
    chkb("fr_req_ready", req_ready, 1'b1);

    // Flush in IDLE blocks the accept.
    req_valid = 1; req_addr = 32'h8000_0000; flush = 1;
    #1 chkb("fi_req_ready", req_ready, 1'b0);
    @(negedge clk);
    req_valid = 0; flush = 0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen = seen | resp_valid;
    end
    chkb("fi_no_resp", seen, 1'b0);

    // Asynchronous reset mid-BUSY.
    resp_ready = 1; req_valid = 1; req_addr = 32'h8000_0008;
    @(negedge clk);
    req_valid = 0;
    #2 rst = 0;
    #1 chkb("rb_req_ready", req_ready, 1'b1);
    chkb("rb_valid", resp_valid, 1'b0);
    @(negedge clk);
    rst = 1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen = seen | resp_valid;
    end
    chkb("rb_no_resp", seen, 1'b0);

    // Asynchronous reset while a response is held.
    resp_ready = 0; req_valid = 1; req_addr = 32'h8000_0008;
    @(negedge clk);
    req_valid = 0;
    wait_valid(lat);
    chkb("rr_valid", resp_valid, 1'b1);
    #2 rst = 0;
    #1 chkb("rr_valid_drop", resp_valid, 1'b0);
    chk("rr_data_clr", resp_data, 32'h0);
    @(negedge clk);
    rst = 1;
    fetch(32'h8000_0FFC, d, e, lat);
    chk("rr_after_data", d, 32'hCAFE_F00D);
    chk("rr_after_lat", lat, 2);

    // Latency sweep across instances.
    rst = 0;
    @(negedge clk);
    rst = 1; req_valid = 1; req_addr = 32'h8000_0000; resp_ready = 1;
    @(negedge clk);
    req_valid = 0;
    l1 = -1; l2 = -1; l15 = -1; d15 = 32'h0;
    for (int n = 0; n <= 20; n++) begin
      if (rv1 && l1 < 0) l1 = n;
      if (resp_valid && l2 < 0) l2 = n;
      if (rv15 && l15 < 0) begin
        l15 = n;
        d15 = rd15;
      end
      @(negedge clk);
    end
    chk("sw_lat1", l1, 1);
    chk("sw_lat2", l2, 2);
    chk("sw_lat15", l15, 15);
    chk("sw_data15", d15, 32'h0000_0413);

    // Same-edge load collision on the BUSY->RESP edge.
    req_valid = 1; req_addr = 32'h8000_000C; resp_ready = 1;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    ld_en = 1; ld_addr = 10'd3; ld_data = 32'h1111_1111;
    @(negedge clk);
    ld_en = 0;
    chkb("col_valid", resp_valid, 1'b1);
    chk("col_old_data", resp_data, 32'h2222_2222);
    @(negedge clk);
    fetch(32'h8000_000C, d, e, lat);
    chk("col_new_data", d, 32'h1111_1111);
    chkb("col_new_err", e, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
